// File: rtl/wshb_rr_arbiter.sv
// rtl/wshb_rr_arbiter.sv - two-master round-robin Wishbone arbiter with hold watchdog
module wshb_rr_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int SW       = DW / 8,
    parameter int MAX_HOLD = 1024,
    parameter int HCW      = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [SW-1:0] m0_sel,
    input  logic [2:0]    m0_cti,
    input  logic [1:0]    m0_bte,
    input  logic [DW-1:0] m0_dat_ms,
    output logic          m0_ack,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [SW-1:0] m1_sel,
    input  logic [2:0]    m1_cti,
    input  logic [1:0]    m1_bte,
    input  logic [DW-1:0] m1_dat_ms,
    output logic          m1_ack,
    output logic [DW-1:0] m_dat_sm,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [SW-1:0] s_sel,
    output logic [2:0]    s_cti,
    output logic [1:0]    s_bte,
    output logic [DW-1:0] s_dat_ms,
    input  logic [DW-1:0] s_dat_sm,
    input  logic          s_ack,
    output logic [1:0]    gnt,
    output logic          hold_ovf
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] G0   = 2'b01;
    localparam logic [1:0] G1   = 2'b10;

    logic [1:0]     state;
    logic [1:0]     nextState;
    logic           last;
    logic [HCW-1:0] holdCnt;
    logic           contended;

    // A grant only ends when its owner drops cyc; ties go to the master not served last.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) nextState = last ? G0 : G1;
                else if (m0_cyc)      nextState = G0;
                else if (m1_cyc)      nextState = G1;
            end
            G0:      if (!m0_cyc) nextState = m1_cyc ? G1 : IDLE;
            G1:      if (!m1_cyc) nextState = m0_cyc ? G0 : IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign contended = m0_cyc && m1_cyc && (state == G0 || state == G1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            holdCnt  <= '0;
            hold_ovf <= 1'b0;
        end else begin
            state <= nextState;
            if (state == G0 && !m0_cyc) last <= 1'b0;
            if (state == G1 && !m1_cyc) last <= 1'b1;
            // Watchdog only observes; the owner keeps the bus regardless.
            if (contended) begin
                if (holdCnt != HCW'(MAX_HOLD)) holdCnt <= holdCnt + 1'b1;
                if (holdCnt >= HCW'(MAX_HOLD - 1)) hold_ovf <= 1'b1;
            end else begin
                holdCnt <= '0;
            end
        end
    end

    assign gnt = state;

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        s_dat_ms = '0;
        case (gnt)
            G0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_cti    = m0_cti;
                s_bte    = m0_bte;
                s_dat_ms = m0_dat_ms;
            end
            G1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_cti    = m1_cti;
                s_bte    = m1_bte;
                s_dat_ms = m1_dat_ms;
            end
            default: ;
        endcase
    end

    assign m0_ack   = s_ack & gnt[0];
    assign m1_ack   = s_ack & gnt[1];
    assign m_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb/tb_wshb_rr_arbiter.sv - directed self-checking bench for wshb_rr_arbiter
module tb_wshb_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic [2:0]    m0_cti, m1_cti, s_cti;
    logic [1:0]    m0_bte, m1_bte, s_bte;
    logic [DW-1:0] m0_dat_ms, m1_dat_ms, s_dat_ms, s_dat_sm, m_dat_sm;
    logic          m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack;
    logic [1:0]    gnt;
    logic          hold_ovf;
    logic          slvAuto, sAckDrv;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    // Auto mode models a zero-wait-state slave that acks every strobe.
    assign s_ack = slvAuto ? (s_cyc & s_stb) : sAckDrv;

    wshb_rr_arbiter #(.AW(AW), .DW(DW), .SW(SW), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
        .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_dat_ms(m0_dat_ms), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
        .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_dat_ms(m1_dat_ms), .m1_ack(m1_ack),
        .m_dat_sm(m_dat_sm), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_dat_ms(s_dat_ms),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .gnt(gnt), .hold_ovf(hold_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else nPass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_adr = '0; m1_adr = '0; m0_sel = '0; m1_sel = '0;
        m0_cti = '0; m1_cti = '0; m0_bte = '0; m1_bte = '0;
        m0_dat_ms = '0; m1_dat_ms = '0; s_dat_sm = '0;
        slvAuto = 1'b0; sAckDrv = 1'b0;
    endtask

    task automatic rstSeq();
        rst_n = 1'b0;
        clearInputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int ackCnt, ack0, ack1, b0, b1, viol, switches, d;
    logic a0, a1;
    logic [1:0] g, prevG, cur;

    initial begin
        rst_n = 1'b0;
        clearInputs();
        tick();
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_ovf", hold_ovf, 0);
        tick();
        rst_n = 1'b1;

        // Tie after reset goes to m0; handover leaves one idle bus cycle.
        tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        #1 chk("tie_latency", gnt, 2'b00);
        tick();
        #1 chk("tie1_gnt", gnt, 2'b01);
        chk("tie1_scyc", s_cyc, 1);
        m0_cyc = 0; m0_stb = 0;
        #1 chk("gap_scyc", s_cyc, 0);
        chk("gap_gnt", gnt, 2'b01);
        tick();
        #1 chk("handover_gnt", gnt, 2'b10);
        chk("handover_scyc", s_cyc, 1);
        m1_cyc = 0; m1_stb = 0;
        tick();
        #1 chk("idle_gnt", gnt, 2'b00);
        m0_cyc = 1; m1_cyc = 1;
        tick();
        #1 chk("tie2_gnt", gnt, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        tick();
        m0_cyc = 1; m0_stb = 1;
        tick();
        #1 chk("regrant_m0", gnt, 2'b01);

        // Reset in the middle of an m0 transfer.
        sAckDrv = 1;
        #1 chk("m0_ack_live", m0_ack, 1);
        rst_n = 1'b0;
        #1 chk("midrst_scyc", s_cyc, 0);
        chk("midrst_gnt", gnt, 2'b00);
        chk("midrst_acks", {m1_ack, m0_ack}, 2'b00);
        chk("midrst_ovf", hold_ovf, 0);
        tick();
        clearInputs();
        rst_n = 1'b1;

        // Routing: m1 owns the bus for an 8-beat burst.
        tick();
        sAckDrv = 1; m0_adr = 32'hDEAD0000;
        #1 chk("idle_ack_ignored", {m1_ack, m0_ack}, 2'b00);
        sAckDrv = 0;
        m1_cyc = 1; m1_stb = 1; m1_sel = 4'hF; m1_cti = 3'b010; m1_adr = 32'h1000;
        tick();
        ackCnt = 0;
        for (int i = 0; i < 8; i++) begin
            m1_adr = 32'h1000 + 32'(4 * i);
            s_dat_sm = DW'(i);
            sAckDrv = 1;
            #1;
            chk("rt_m1_ack", m1_ack, 1);
            chk("rt_m0_ack", m0_ack, 0);
            chk("rt_adr", s_adr, 32'h1000 + 4 * i);
            chk("rt_dat", m_dat_sm, i);
            ackCnt += int'(m1_ack);
            tick();
        end
        chk("rt_ack_count", ackCnt, 8);
        chk("rt_cti", s_cti, 3'b010);
        chk("rt_sel", s_sel, 4'hF);
        sAckDrv = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // Hold watchdog with MAX_HOLD=16.
        rstSeq();
        m0_cyc = 1; m0_stb = 1;
        tick();
        m1_cyc = 1; m1_stb = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            #1;
            if (k == 15) chk("hold_15", hold_ovf, 0);
            if (k == 16) chk("hold_16", hold_ovf, 1);
            if (k == 40) chk("hold_no_release", gnt, 2'b01);
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        #1 chk("hold_after_gnt", gnt, 2'b10);
        chk("hold_sticky", hold_ovf, 1);

        // Fairness: both masters run back-to-back 4-beat bursts.
        rstSeq();
        slvAuto = 1;
        a0 = 0; a1 = 0; b0 = 0; b1 = 0; ack0 = 0; ack1 = 0;
        viol = 0; switches = 0; prevG = 2'b00; cur = 2'b00;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (!m0_cyc) begin m0_cyc = 1; m0_stb = 1; b0 = 0; end
            else if (a0) begin b0++; if (b0 == 4) begin m0_cyc = 0; m0_stb = 0; end end
            if (!m1_cyc) begin m1_cyc = 1; m1_stb = 1; b1 = 0; end
            else if (a1) begin b1++; if (b1 == 4) begin m1_cyc = 0; m1_stb = 0; end end
            #1;
            a0 = m0_ack; a1 = m1_ack;
            ack0 += int'(a0); ack1 += int'(a1);
            g = gnt;
            if (g != 2'b00 && g != prevG) begin
                if (g == cur) viol++;
                cur = g;
                switches++;
            end
            prevG = g;
        end
        d = ack0 - ack1;
        if (d < 0) d = -d;
        chk("fair_alternate", viol, 0);
        chk("fair_ack_diff", d <= 4, 1);
        chk("fair_throughput", (ack0 + ack1) >= 790, 1);
        chk("fair_switches", switches >= 195, 1);
        chk("fair_no_ovf", hold_ovf, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
